// File: rtl/btn_conditioner.sv
// btn_conditioner: synchroniser, debouncer and press-pulse stretcher for the
// three punch buttons. Optional auto-repeat while a button is held is enabled
// by defining BTN_AUTOREPEAT_EN.

// One button channel: 2-flop synchroniser, REL/HLD debounce FSM, stretch counter.
module btn_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STRETCH_CYCLES  = 65536,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_nxt
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] ST_MAX = SW'(STRETCH_CYCLES);

    typedef enum logic {REL, HLD} state_t;

    logic [1:0]    sync;
    logic          s;
    state_t        state;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] st_cnt;
    logic [SW-1:0] st_nxt;
    logic          accept;
    logic          reload;
    logic          rep_fire;

    assign s = sync[1];

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rp_cnt;

    assign rep_fire = (state == HLD) && (rp_cnt == RP_MAX);

    // Repeat period counter: runs only while held, wraps on each repeat reload.
    always_ff @(posedge clk) begin
        if (!rst || state == REL) begin
            rp_cnt <= '0;
        end else if (rep_fire) begin
            rp_cnt <= '0;
        end else begin
            rp_cnt <= rp_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Press acceptance and next stretch count; a reload extends a running pulse.
    always_comb begin
        accept    = (state == REL) && s && (db_cnt == DB_MAX);
        reload    = accept || rep_fire;
        st_nxt    = st_cnt;
        if (reload) begin
            st_nxt = ST_MAX;
        end else if (st_cnt != '0) begin
            st_nxt = st_cnt - 1'b1;
        end
        press_nxt = (st_nxt != '0);
    end

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Debounce FSM: a level change needs DEBOUNCE_CYCLES consecutive opposite samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= REL;
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            case (state)
                REL: begin
                    if (!s) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_MAX) begin
                        state  <= HLD;
                        db_cnt <= '0;
                        level  <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HLD: begin
                    if (s) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_MAX) begin
                        state  <= REL;
                        db_cnt <= '0;
                        level  <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= REL;
                    db_cnt <= '0;
                    level  <= 1'b0;
                end
            endcase
        end
    end

    // Stretch counter and registered pulse; the counter saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_cnt <= '0;
            press  <= 1'b0;
        end else begin
            st_cnt <= st_nxt;
            press  <= press_nxt;
        end
    end
endmodule

// Top: three independent channels plus the registered any-press flag.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STRETCH_CYCLES  = 65536,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic       btn_any
);
    localparam int NUM_BTN = 3;

    logic [NUM_BTN-1:0] press_nxt;

    if (DEBOUNCE_CYCLES < 2 || STRETCH_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("btn_conditioner: illegal parameter values");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STRETCH_CYCLES (STRETCH_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (btn_raw[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .press_nxt(press_nxt[i])
        );
    end

    // btn_any is registered from the same next-state as btn_press, so no extra lag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_any <= 1'b0;
        end else begin
            btn_any <= |press_nxt;
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus pushes model expectations,
// a monitor pops and compares after every clock edge.
module tb_btn_conditioner;
    localparam int D = 4;
    localparam int S = 3;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       btn_any;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .STRETCH_CYCLES (S),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_any  (btn_any)
    );

    typedef struct {
        int         edge_n;
        logic [2:0] level;
        logic [2:0] press;
        logic       any;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: pin history by edge number, run lengths, last pulse start.
    int         k = 0;
    int         last_rst = -100;
    logic [2:0] hist [0:8191];
    int         run  [3];
    int         last_load [3];
    int         entry [3];
    logic [2:0] lvl;

    function automatic void model_step(input logic r, input logic [2:0] b);
        exp_t       e;
        logic [2:0] pr;
        logic       samp;
        logic       load;
        k = k + 1;
        hist[k] = b;
        if (!r) begin
            last_rst = k;
            lvl = 3'b000;
            for (int c = 0; c < 3; c++) begin
                run[c] = 0;
                last_load[c] = -1000;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                // Debounce logic sees the pin as it was two edges ago, unless reset intervened.
                samp = (k - 2 > last_rst) ? hist[k-2][c] : 1'b0;
                load = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                if (lvl[c] && k > entry[c] && ((k - entry[c]) % R) == 0) load = 1'b1;
`endif
                if (samp != lvl[c]) run[c] = run[c] + 1;
                else run[c] = 0;
                if (run[c] == D) begin
                    lvl[c] = ~lvl[c];
                    run[c] = 0;
                    if (lvl[c]) begin
                        load = 1'b1;
                        entry[c] = k;
                    end
                end
                if (load) last_load[c] = k;
            end
        end
        for (int c = 0; c < 3; c++) pr[c] = ((k - last_load[c]) < S);
        e.edge_n = k;
        e.level  = lvl;
        e.press  = pr;
        e.any    = |pr;
        sb_q.push_back(e);
    endfunction

    task automatic drive(input logic r, input logic [2:0] b);
        @(negedge clk);
        rst = r;
        btn_raw = b;
        model_step(r, b);
    endtask

    task automatic hold(input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, b);
    endtask

    // Monitor: the DUT presents a result after every edge; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (btn_level === e.level) passed++;
                else $display("FAIL level edge %0d: got %b expected %b", e.edge_n, btn_level, e.level);
                checks++;
                if (btn_press === e.press) passed++;
                else $display("FAIL press edge %0d: got %b expected %b", e.edge_n, btn_press, e.press);
                checks++;
                if (btn_any === e.any) passed++;
                else $display("FAIL any edge %0d: got %b expected %b", e.edge_n, btn_any, e.any);
            end
        end
    end

    initial begin
        int         cnt [3];
        logic [2:0] val;
        logic       r;
        int         waited;
        lvl = 3'b000;
        for (int c = 0; c < 3; c++) begin
            run[c] = 0;
            last_load[c] = -1000;
            entry[c] = 0;
            cnt[c] = 0;
        end
        val = 3'b000;

        // Reset
        drive(1'b0, 3'b000);
        drive(1'b0, 3'b000);
        // Clean press on button 1, held, then released
        hold(3'b001, 20);
        hold(3'b000, 15);
        // Bounce on button 2: 3 high, 1 low, 3 high, then low
        hold(3'b010, 3);
        hold(3'b000, 1);
        hold(3'b010, 3);
        hold(3'b000, 12);
        // Simultaneous press on buttons 1 and 3, held long enough for auto-repeat
        hold(3'b101, 30);
        hold(3'b000, 12);
        // Reset on the edge after the pulse rises, button still held
        hold(3'b001, 6);
        drive(1'b0, 3'b001);
        hold(3'b001, 15);
        hold(3'b000, 12);
        // Two presses close together: second acceptance while a pulse may still run
        hold(3'b100, 5);
        hold(3'b000, 5);
        hold(3'b100, 8);
        hold(3'b000, 10);

        // Randomised bouncy pins with occasional resets
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < 3; c++) begin
                if (cnt[c] == 0) begin
                    val[c] = 1'($urandom_range(0, 1));
                    cnt[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 6);
                end
                cnt[c] = cnt[c] - 1;
            end
            r = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            drive(r, val);
        end
        hold(3'b000, 12);

        // All expectations must have been consumed by the monitor
        waited = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checks++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
